// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner and a legacy legend lookup for consumers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } state_e;

    // 4x4 legacy keymap: key index -> hex legend printed on the keycap.
    function automatic logic [3:0] keymap(input logic [3:0] idx);
        logic [3:0] legend;
        case (idx)
            4'd0:    legend = 4'h1;
            4'd1:    legend = 4'h2;
            4'd2:    legend = 4'h3;
            4'd3:    legend = 4'hA;
            4'd4:    legend = 4'h4;
            4'd5:    legend = 4'h5;
            4'd6:    legend = 4'h6;
            4'd7:    legend = 4'hB;
            4'd8:    legend = 4'h7;
            4'd9:    legend = 4'h8;
            4'd10:   legend = 4'h9;
            4'd11:   legend = 4'hC;
            4'd12:   legend = 4'hE;
            4'd13:   legend = 4'h0;
            4'd14:   legend = 4'hF;
            default: legend = 4'hD;
        endcase
        return legend;
    endfunction

endpackage

// File: rtl/key_event_slot.sv
// One-entry valid/ready event slot with a sticky overflow flag.
module key_event_slot
    import keypad_pkg::*;
#(
    parameter int unsigned CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              post_valid,
    input  logic [CODE_W-1:0] post_code,
    input  logic              post_rel,
    input  logic              ready,
    input  logic              overflow_clr,
    output logic              valid,
    output logic [CODE_W-1:0] code,
    output logic              rel,
    output logic              overflow
);

    logic              valid_q, valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              rel_q, rel_d;
    logic              overflow_q, overflow_d;
    logic              load;
    logic              drop;

    // Load when the slot is empty or draining this cycle; otherwise drop and flag.
    always_comb begin
        load       = post_valid & (~valid_q | ready);
        drop       = post_valid & valid_q & ~ready;
        valid_d    = load | (valid_q & ~ready);
        code_d     = load ? post_code : code_q;
        rel_d      = load ? post_rel : rel_q;
        overflow_d = overflow_clr ? 1'b0 : (overflow_q | drop);
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            code_q     <= '0;
            rel_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            code_q     <= code_d;
            rel_q      <= rel_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid    = valid_q;
    assign code     = code_q;
    assign rel      = rel_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad controller: one key tracked at a time, press/repeat/release
// events delivered through a one-entry valid/ready slot.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned N_ROWS    = 4,
    parameter int unsigned N_COLS    = 4,
    parameter int unsigned DWELL     = 16,
    parameter int unsigned REP_DELAY = 32,
    parameter int unsigned REP_RATE  = 8,
    localparam int unsigned CODE_W   = $clog2(N_ROWS * N_COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] row_debounced,
    input  logic              repeat_en,
    output logic [N_COLS-1:0] col,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CODE_W-1:0] key_code,
    output logic              key_release,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int unsigned ROW_W   = $clog2(N_ROWS);
    localparam int unsigned COL_W   = $clog2(N_COLS);
    localparam int unsigned DW_W    = $clog2(DWELL);
    localparam int unsigned REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    state_e            state_q, state_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [COL_W-1:0]  col_index_q, col_index_d, col_next;
    logic [ROW_W-1:0]  row_q, row_d, low_row;
    logic [REP_W-1:0]  rep_q, rep_d, rep_target;
    logic              rep_first_q, rep_first_d;
    logic [N_COLS-1:0] col_q, col_d;
    logic              sample, found, row_hit;
    logic              post_valid, post_rel;
    logic [CODE_W-1:0] post_code;

    // Next-state, scan position, repeat timing and event posting.
    always_comb begin
        state_d     = state_q;
        col_index_d = col_index_q;
        row_d       = row_q;
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        post_valid  = 1'b0;
        post_rel    = 1'b0;

        sample  = (dwell_q == DW_W'(DWELL - 1));
        dwell_d = sample ? '0 : dwell_q + DW_W'(1);
        col_next = (col_index_q == COL_W'(N_COLS - 1)) ? '0 : col_index_q + COL_W'(1);
        row_hit  = row_debounced[row_q];
        rep_target = rep_first_q ? REP_W'(REP_RATE) : REP_W'(REP_DELAY);
        post_code  = CODE_W'(row_q) * CODE_W'(N_COLS) + CODE_W'(col_index_q);

        found   = 1'b0;
        low_row = '0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            if (row_debounced[i] && !found) begin
                found   = 1'b1;
                low_row = ROW_W'(i);
            end
        end

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (found) begin
                        row_d   = low_row;
                        state_d = CONFIRM;
                    end else begin
                        col_index_d = col_next;
                    end
                end
            end
            CONFIRM: begin
                if (sample) begin
                    if (row_hit) begin
                        state_d     = HELD;
                        post_valid  = 1'b1;
                        rep_d       = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        state_d     = SCAN;
                        col_index_d = col_next;
                    end
                end
            end
            HELD: begin
                if (sample) begin
                    if (!row_hit) begin
                        post_valid  = 1'b1;
                        post_rel    = 1'b1;
                        state_d     = SCAN;
                        col_index_d = col_next;
                    end else if (repeat_en) begin
                        if (rep_q + REP_W'(1) == rep_target) begin
                            post_valid  = 1'b1;
                            rep_d       = '0;
                            rep_first_d = 1'b1;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        if (!repeat_en) begin
            rep_d       = '0;
            rep_first_d = 1'b0;
        end

        // Decoding the next index keeps col aligned with col_index_q.
        col_d = ~(N_COLS'(1) << col_index_d);
    end

    // Scanner state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SCAN;
            dwell_q     <= '0;
            col_index_q <= '0;
            row_q       <= '0;
            rep_q       <= '0;
            rep_first_q <= 1'b0;
            col_q       <= ~N_COLS'(1);
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            col_index_q <= col_index_d;
            row_q       <= row_d;
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
            col_q       <= col_d;
        end
    end

    assign col = col_q;

    key_event_slot #(
        .CODE_W(CODE_W)
    ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .post_valid   (post_valid),
        .post_code    (post_code),
        .post_rel     (post_rel),
        .ready        (key_ready),
        .overflow_clr (overflow_clr),
        .valid        (key_valid),
        .code         (key_code),
        .rel          (key_release),
        .overflow     (overflow)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: physical key matrix driven from the scanner's columns,
// expected events derived from key positions and dwell arithmetic.
module tb_keypad_scanner;

    localparam int D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] row0;
    logic       repeat_en, key_ready, overflow_clr;
    logic [3:0] col0;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_release, overflow;

    logic [1:0] row1;
    logic [7:0] col1;
    logic       kv1, kr1, ov1;
    logic [3:0] kc1;
    logic       k17;

    logic [3:0] key_m [4];

    int checks = 0;
    int errors = 0;
    int cyc;
    int ev_code[$];
    int ev_rel[$];
    int ev_cyc[$];

    keypad_scanner u_dut (
        .clk           (clk),
        .rst           (rst),
        .row_debounced (row0),
        .repeat_en     (repeat_en),
        .col           (col0),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .key_code      (key_code),
        .key_release   (key_release),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    keypad_scanner #(
        .N_ROWS(2),
        .N_COLS(8)
    ) u_dut8 (
        .clk           (clk),
        .rst           (rst),
        .row_debounced (row1),
        .repeat_en     (1'b0),
        .col           (col1),
        .key_valid     (kv1),
        .key_ready     (1'b1),
        .key_code      (kc1),
        .key_release   (kr1),
        .overflow      (ov1),
        .overflow_clr  (1'b0)
    );

    // A row reads high when a closed key sits on the column driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) row0[r] = |(key_m[r] & ~col0);
    end
    assign row1 = {k17 & ~col1[7], 1'b0};

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst && key_valid && key_ready) begin
            ev_code.push_back(int'(key_code));
            ev_rel.push_back(int'(key_release));
            ev_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int i, input int code, input int rel);
        if (i < ev_code.size()) begin
            check({tag, "_code"}, ev_code[i], code);
            check({tag, "_rel"}, ev_rel[i], rel);
        end else begin
            check({tag, "_missing"}, ev_code.size(), i + 1);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        for (int i = 0; i < 100000 && cyc < t; i++) step(1);
    endtask

    task automatic wait_events(input int n, input int budget);
        for (int i = 0; i < budget && ev_code.size() < n; i++) step(1);
    endtask

    task automatic clear_ev();
        ev_code.delete();
        ev_rel.delete();
        ev_cyc.delete();
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) key_m[r] = 4'b0000;
    endtask

    initial begin
        int r, c, h;
        logic [7:0] exp8;

        rst = 1'b0;
        repeat_en = 1'b0;
        key_ready = 1'b1;
        overflow_clr = 1'b0;
        k17 = 1'b0;
        clear_keys();
        step(3);

        check("rst_col", col0, 4'b1110);
        check("rst_valid", key_valid, 1'b0);
        check("rst_code", key_code, 4'd0);
        check("rst_release", key_release, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_col8", col1, 8'hFE);
        check("rst_valid8", kv1, 1'b0);

        // Brief press of row0/col0: seen once, not confirmed.
        rst = 1'b1;
        key_m[0] = 4'b0001;
        wait_cyc(D);
        key_m[0] = 4'b0000;
        check("confirm_holds_col", col0, 4'b1110);
        check("walk8_1", col1, 8'hFD);
        wait_cyc(2 * D);
        check("scan_resumes_col1", col0, 4'b1101);
        check("no_event_brief", ev_code.size(), 0);
        for (int k = 2; k < 10; k++) begin
            wait_cyc(k * D);
            exp8 = ~(8'd1 << (k % 8));
            check("walk8", col1, exp8);
        end

        // Row1/col2 held three dwells: one press then one release, code 6.
        clear_ev();
        for (int i = 0; i < 20 * D && col0 !== 4'b1011; i++) step(1);
        key_m[1] = 4'b0100;
        step(3 * D);
        key_m[1] = 4'b0000;
        step(3 * D);
        check("b_count", ev_code.size(), 2);
        check_ev("b_press", 0, 6, 0);
        check_ev("b_release", 1, 6, 1);
        if (ev_cyc.size() >= 2) begin
            check("b_latency", ev_cyc[0] % D, 0);
            check("b_gap", ev_cyc[1] - ev_cyc[0], 2 * D);
        end

        // Random single keys, no repeat.
        for (int t = 0; t < 6; t++) begin
            clear_ev();
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            h = (4 + 2 + $urandom_range(0, 3)) * D + $urandom_range(0, D - 1);
            key_m[r] = 4'b0001 << c;
            step(h);
            clear_keys();
            step(3 * D);
            check("rnd_count", ev_code.size(), 2);
            check_ev("rnd_press", 0, r * 4 + c, 0);
            check_ev("rnd_release", 1, r * 4 + c, 1);
            step($urandom_range(1, 2 * D));
        end

        // Auto-repeat on row3/col3.
        clear_ev();
        repeat_en = 1'b1;
        key_m[3] = 4'b1000;
        wait_events(4, 80 * D);
        key_m[3] = 4'b0000;
        step(2 * D);
        repeat_en = 1'b0;
        check("rep_count", ev_code.size(), 5);
        check_ev("rep_press", 0, 15, 0);
        check_ev("rep_first", 1, 15, 0);
        check_ev("rep_second", 2, 15, 0);
        check_ev("rep_third", 3, 15, 0);
        check_ev("rep_release", 4, 15, 1);
        if (ev_cyc.size() >= 4) begin
            check("rep_delay", ev_cyc[1] - ev_cyc[0], 32 * D);
            check("rep_rate1", ev_cyc[2] - ev_cyc[1], 8 * D);
            check("rep_rate2", ev_cyc[3] - ev_cyc[2], 8 * D);
        end

        // Stalled consumer: press held in slot, release dropped, overflow sticky.
        clear_ev();
        key_ready = 1'b0;
        key_m[2] = 4'b0010;
        for (int i = 0; i < 12 * D && key_valid !== 1'b1; i++) step(1);
        step(D);
        key_m[2] = 4'b0000;
        step(3 * D);
        check("ovf_valid", key_valid, 1'b1);
        check("ovf_code", key_code, 4'd9);
        check("ovf_rel", key_release, 1'b0);
        check("ovf_set", overflow, 1'b1);
        overflow_clr = 1'b1;
        step(1);
        check("ovf_clr", overflow, 1'b0);
        overflow_clr = 1'b0;
        key_ready = 1'b1;
        step(2);
        check("ovf_drained", key_valid, 1'b0);
        check("ovf_ev_count", ev_code.size(), 1);
        check_ev("ovf_ev", 0, 9, 0);

        // Two rows on col0: lowest row wins; reset mid-hold leaves no release.
        clear_ev();
        key_m[1] = 4'b0001;
        key_m[2] = 4'b0001;
        wait_events(1, 12 * D);
        check_ev("multi_press", 0, 4, 0);
        step(2 * D);
        check("multi_single", ev_code.size(), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_col", col0, 4'b1110);
        check("mid_rst_valid", key_valid, 1'b0);
        check("mid_rst_code", key_code, 4'd0);
        check("mid_rst_rel", key_release, 1'b0);
        check("mid_rst_ovf", overflow, 1'b0);
        clear_keys();
        step(3);
        rst = 1'b1;
        step(6 * D);
        check("no_release_after_rst", ev_code.size(), 1);

        // 2x8 instance: row1/col7 reports code 15.
        k17 = 1'b1;
        for (int i = 0; i < 12 * D && kv1 !== 1'b1; i++) step(1);
        check("dut8_valid", kv1, 1'b1);
        check("dut8_code", kc1, 4'd15);
        check("dut8_rel", kr1, 1'b0);
        k17 = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
